// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue side uses the slave modport; the fetch/decode side uses the master modport.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 1
);
  logic              flush;
  logic              in_valid;
  logic [15:0]       in_instr;
  logic [15:0]       in_pc;
  logic [15:0]       in_pcPlusTwo;
  logic              in_ready;
  logic              pc_hold;
  logic              out_valid;
  logic [15:0]       out_instr;
  logic [15:0]       out_pc;
  logic [15:0]       out_pcPlusTwo;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              halted;

  modport master (
    output flush, in_valid, in_instr, in_pc, in_pcPlusTwo, out_ready,
    input  in_ready, pc_hold, out_valid, out_instr, out_pc, out_pcPlusTwo, count, halted
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_pcPlusTwo, out_ready,
    output in_ready, pc_hold, out_valid, out_instr, out_pc, out_pcPlusTwo, count, halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched bundles between fetch and decode.
// It is cleared by a redirect and locks out further fetch once a HALT has been queued.
module fetch_queue #(
  parameter int unsigned ADDR_W = 1
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave fq
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [15:0] NOP   = 16'h0800;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
  } bundle_t;

  bundle_t           mem [DEPTH];
  bundle_t           head;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count_q;
  logic              halted_q;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              push;
  logic              pop;
  logic              is_halt;

  // Handshake qualifiers, derived from registered state only.
  always_comb begin
    in_ready_c  = (count_q != CNT_W'(DEPTH)) && !halted_q;
    out_valid_c = (count_q != '0);
    push        = fq.in_valid && in_ready_c;
    pop         = out_valid_c && fq.out_ready;
    is_halt     = (fq.in_instr[15:11] == 5'b00000);
  end

  // Pointers, occupancy and the HALT lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (fq.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (pop)  rptr <= rptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push && is_halt) halted_q <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst && !fq.flush && push) begin
      mem[wptr] <= '{instr: fq.in_instr, pc: fq.in_pc, pc_plus_two: fq.in_pcPlusTwo};
    end
  end

  // Head read; an empty queue presents a NOP bundle.
  always_comb begin
    head = mem[rptr];
    if (!out_valid_c) head = '{instr: NOP, pc: 16'h0000, pc_plus_two: 16'h0000};
  end

  assign fq.in_ready      = in_ready_c;
  assign fq.pc_hold       = !in_ready_c;
  assign fq.out_valid     = out_valid_c;
  assign fq.out_instr     = head.instr;
  assign fq.out_pc        = head.pc;
  assign fq.out_pcPlusTwo = head.pc_plus_two;
  assign fq.count         = count_q;
  assign fq.halted        = halted_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue scoreboard holds expected bundles,
// and a small occupancy/HALT model predicts the handshake outputs every cycle.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(1)) fq ();
  fetch_queue #(.ADDR_W(1)) dut (.clk(clk), .rst(rst), .fq(fq));

  logic [47:0] sb [$];
  int          mcnt   = 0;
  logic        mhalt  = 1'b0;
  logic        chk_en = 1'b0;
  logic        saw_flushed = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input logic r, input logic fl, input logic v,
                      input logic [15:0] instr, input logic [15:0] pc, input logic ordy);
    logic exp_rdy;
    logic exp_vld;
    logic psh;
    logic pp;
    @(negedge clk);
    exp_rdy = (mcnt != 2) && !mhalt;
    exp_vld = (mcnt != 0);
    if (fq.out_valid === 1'b1 && fq.out_pc === 16'h0100) saw_flushed = 1'b1;
    if (chk_en) begin
      check("in_ready",  48'(fq.in_ready),  48'(exp_rdy));
      check("pc_hold",   48'(fq.pc_hold),   48'(!exp_rdy));
      check("out_valid", 48'(fq.out_valid), 48'(exp_vld));
      check("count",     48'(fq.count),     48'(mcnt));
      check("halted",    48'(fq.halted),    48'(mhalt));
      if (exp_vld) check("head", {fq.out_instr, fq.out_pc, fq.out_pcPlusTwo}, sb[0]);
      else         check("empty_head", {fq.out_instr, fq.out_pc, fq.out_pcPlusTwo}, {16'h0800, 32'h0});
    end
    rst             = r;
    fq.flush        = fl;
    fq.in_valid     = v;
    fq.in_instr     = instr;
    fq.in_pc        = pc;
    fq.in_pcPlusTwo = pc + 16'd2;
    fq.out_ready    = ordy;
    psh = v && exp_rdy;
    pp  = exp_vld && ordy;
    if (!r || fl) begin
      sb.delete();
      mcnt  = 0;
      mhalt = 1'b0;
    end else begin
      if (pp) begin
        sb.delete(0);
        mcnt--;
      end
      if (psh) begin
        sb.push_back({instr, pc, pc + 16'd2});
        mcnt++;
        if (instr[15:11] == 5'b00000) mhalt = 1'b1;
      end
    end
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b0; fq.flush = 1'b0; fq.in_valid = 1'b0; fq.in_instr = '0;
    fq.in_pc = '0; fq.in_pcPlusTwo = '0; fq.out_ready = 1'b0;

    // Reset for two cycles with fetch presenting a bundle.
    step(1'b0, 1'b0, 1'b1, 16'h4123, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h4123, 16'h0000, 1'b0);

    // Fill to full with backpressure; third bundle must be refused.
    step(1'b1, 1'b0, 1'b1, 16'h4123, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4002, 16'h0002, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4004, 16'h0004, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Full with pop: no push-through, then drain.
    step(1'b1, 1'b0, 1'b1, 16'h4006, 16'h0006, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Streaming with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'h4000 + 16'(i), 16'h0010 + 16'(2 * i), 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Flush with a full queue and a same-cycle push.
    step(1'b1, 1'b0, 1'b1, 16'h4030, 16'h0030, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4032, 16'h0032, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h4100, 16'h0100, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // HALT lock: later fetch refused, HALT drains, flush releases.
    step(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4400, 16'h0042, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4400, 16'h0042, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4400, 16'h0042, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h4400, 16'h0042, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Flush in the same cycle as a HALT push: flush wins.
    step(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0050, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4052, 16'h0052, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    check("flushed_pc_absent", 48'(saw_flushed), 48'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
